fp_dot_product_unit: RTL and testbench

- Sequential dot-product engine built around the existing combinational `floating_point_multiplier` and `floating_point_adder`.
- Accepts a stream of IEEE-754 single-precision operand pairs over a valid/ready handshake and multiplies each pair.
- Folds each product into a running accumulator.
- After LEN pairs, presents the 32-bit sum and a sticky overflow flag on a valid/ready output port.

---
 rtl/fp_dot_product_unit_if.sv | 23 ++
 rtl/fp_dot_product_unit.sv | 202 ++++++++++++++++++++
 tb/tb_fp_dot_product_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fp_dot_product_unit_if.sv
// Operand-pair input stream and result output stream of the dot-product engine.
// Pure wiring bundle, no latency.
// Backpressure: in_ready / out_ready travel on the same bundle as the data.
interface fp_dot_product_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_overflow
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_overflow
  );
endinterface

// File: rtl/fp_dot_product_unit.sv
// Sequential IEEE-754 single dot product: multiply each pair, fold into a running sum.
// Latency: result valid one edge after the LEN-th accepted pair; period LEN+2 cycles.
// Backpressure: in_ready low while draining or holding; result held until out_ready.

// Combinational single-precision multiplier. Zero/denormal inputs give +0,
// inf/NaN inputs give signed inf, mantissa is truncated. overflow flags a
// finite product whose exponent exceeds the representable range.
module floating_point_multiplier (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        overflow
);
  logic [47:0]        p;
  logic signed [9:0]  e;
  logic [22:0]        m;

  // Mantissa product, exponent sum and normalisation by at most one place
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    p        = '0;
    e        = '0;
    m        = '0;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      result = {a[31] ^ b[31], 8'hFF, 23'd0};
    end else if (a[30:23] != 8'd0 && b[30:23] != 8'd0) begin
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127 + {9'd0, p[47]};
      m = 23'(p >> (p[47] ? 6'd24 : 6'd23));
      if (e >= 10'sd255) begin
        result   = {a[31] ^ b[31], 8'hFF, 23'd0};
        overflow = 1'b1;
      end else if (e > 10'sd0) begin
        result = {a[31] ^ b[31], e[7:0], m};
      end
    end
  end
endmodule

// Combinational single-precision adder. A zero/denormal operand passes the
// other through, inf/NaN passes through, exact cancellation gives +0, the
// smaller operand is truncated on alignment. overflow flags a finite sum
// that rounds past the largest exponent.
module floating_point_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        overflow
);
  logic [31:0]        big;
  logic [31:0]        sml;
  logic [7:0]         d;
  logic [24:0]        mbig;
  logic [24:0]        msml;
  logic [24:0]        sum;
  logic signed [9:0]  e;
  int                 lz;

  // Align to the larger magnitude, add or subtract, then renormalise
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    big      = a;
    sml      = b;
    d        = '0;
    mbig     = '0;
    msml     = '0;
    sum      = '0;
    e        = '0;
    lz       = 0;
    if (a[30:23] == 8'hFF) begin
      result = a;
    end else if (b[30:23] == 8'hFF) begin
      result = b;
    end else if (a[30:23] == 8'd0) begin
      result = b;
    end else if (b[30:23] == 8'd0) begin
      result = a;
    end else begin
      if (b[30:0] > a[30:0]) begin
        big = b;
        sml = a;
      end
      d    = big[30:23] - sml[30:23];
      mbig = {2'b01, big[22:0]};
      msml = (d > 8'd24) ? 25'd0 : ({2'b01, sml[22:0]} >> d);
      e    = 10'(big[30:23]);
      if (big[31] == sml[31]) begin
        sum = mbig + msml;
        if (sum[24]) begin
          sum = sum >> 1;
          e   = e + 10'sd1;
        end
      end else begin
        sum = mbig - msml;
      end
      if (sum != 25'd0) begin
        for (int i = 0; i < 24; i++) begin
          if (sum[i]) lz = 23 - i;
        end
        sum = sum << lz;
        e   = e - 10'(lz);
        if (e >= 10'sd255) begin
          result   = {big[31], 8'hFF, 23'd0};
          overflow = 1'b1;
        end else if (e > 10'sd0) begin
          result = {big[31], e[7:0], sum[22:0]};
        end
      end
    end
  end
endmodule

module fp_dot_product_unit #(
  parameter int LEN   = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_dot_product_unit_if.slave bus,
  output logic                 busy
);
  typedef enum logic [1:0] {ACCEPT, DRAIN, HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [31:0]      prod_reg;
  logic             prod_ovf;
  logic             prod_vld;
  logic [31:0]      acc;
  logic             ovf;
  logic [31:0]      mul_res;
  logic             mul_ovf;
  logic [31:0]      add_res;
  logic             add_ovf;
  logic             accept;
  logic             out_fire;

  floating_point_multiplier u_mul (.a(bus.in_a), .b(bus.in_b), .result(mul_res), .overflow(mul_ovf));
  floating_point_adder      u_add (.a(acc), .b(prod_reg), .result(add_res), .overflow(add_ovf));

  // in_ready is gated by rst so nothing is taken while reset is held
  assign bus.in_ready     = (state == ACCEPT) & ~rst;
  assign bus.out_valid    = (state == HOLD);
  assign bus.out_result   = acc;
  assign bus.out_overflow = ovf;
  assign accept           = bus.in_valid & bus.in_ready;
  assign out_fire         = bus.out_valid & bus.out_ready;
  assign busy             = (state != ACCEPT) | (count != '0) | prod_vld;

  // Next state: collect LEN pairs, one drain edge for the last product, hold result
  always_comb begin
    state_nxt = state;
    case (state)
      ACCEPT:  if (accept && count == LAST) state_nxt = DRAIN;
      DRAIN:   state_nxt = HOLD;
      HOLD:    if (out_fire) state_nxt = ACCEPT;
      default: state_nxt = ACCEPT;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCEPT;
    else     state <= state_nxt;
  end

  // Element counter and product register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      prod_reg <= '0;
      prod_ovf <= 1'b0;
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= accept;
      if (accept) begin
        count    <= (count == LAST) ? '0 : count + 1'b1;
        prod_reg <= mul_res;
        prod_ovf <= mul_ovf;
      end
    end
  end

  // Accumulator and sticky overflow; cleared when the held result is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (out_fire) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (prod_vld) begin
      acc <= add_res;
      ovf <= ovf | prod_ovf | add_ovf;
    end
  end
endmodule

// File: tb/tb_fp_dot_product_unit.sv
// Bench for fp_dot_product_unit: directed vectors plus randomized vectors whose
// operands are multiples of 0.5, so the exact sum is computed with integers.
module tb_fp_dot_product_unit;
  localparam int LEN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   n_chk  = 0;
  int   n_pass = 0;

  fp_dot_product_unit_if bus ();

  fp_dot_product_unit #(.LEN(LEN), .CNT_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, want);
  endtask

  // Value v / 2^fb as IEEE single (|v| < 2^24)
  function automatic logic [31:0] to_fp(input int v, input int fb);
    int          mag;
    int          p;
    logic [31:0] m;
    if (v == 0) return 32'd0;
    mag = (v < 0) ? -v : v;
    p   = 0;
    for (int i = 0; i < 24; i++) if (((mag >> i) & 1) != 0) p = i;
    m = 32'(mag) << (23 - p);
    return {(v < 0) ? 1'b1 : 1'b0, 8'(127 + p - fb), m[22:0]};
  endfunction

  function automatic logic [LEN-1:0][31:0] pack4(input logic [31:0] x0, x1, x2, x3);
    return {x3, x2, x1, x0};
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept
  task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
    logic rdy;
    bit   done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    for (int t = 0; t < 20 && !done; t++) begin
      rdy = bus.in_ready;
      @(posedge clk);
      done = rdy;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input string tag, input logic [LEN-1:0][31:0] va, input logic [LEN-1:0][31:0] vb,
                         input int gmin, input int gmax, input logic [31:0] er, input logic eo, input int stall);
    for (int i = 0; i < LEN; i++) begin
      if (i > 0) repeat ($urandom_range(gmax, gmin)) @(negedge clk);
      send_pair(va[i], vb[i]);
      if (i == 0) chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
    chk({tag, "_lat_early"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_lat"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_result"}, bus.out_result, er);
    chk({tag, "_ovf"}, 32'(bus.out_overflow), 32'(eo));
    for (int s = 0; s < stall; s++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = $urandom;
      bus.in_b     = $urandom;
      @(negedge clk);
      chk({tag, "_stall_vld"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_stall_res"}, bus.out_result, er);
      chk({tag, "_stall_rdy"}, 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_done_vld"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_done_rdy"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1);
  end

  initial begin
    logic [LEN-1:0][31:0] va;
    logic [LEN-1:0][31:0] vb;
    logic [LEN-1:0][31:0] ones;
    int ka;
    int kb;
    int sum;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    ones = pack4(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.out_result, 32'd0);
    chk("rst_ovf", 32'(bus.out_overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_rdy", 32'(bus.in_ready), 32'd1);

    va = pack4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
    run_vec("basic", va, ones, 0, 0, 32'h41200000, 1'b0, 0);
    run_vec("cancel", pack4(32'h3F800000, 32'hBF800000, 32'h40200000, 32'h3F000000), ones,
            0, 0, 32'h40400000, 1'b0, 0);
    run_vec("overflow", pack4(32'h7F000000, 0, 0, 0), pack4(32'h40000000, 0, 0, 0),
            0, 0, 32'h7F800000, 1'b1, 0);
    run_vec("ovf_clear", ones, ones, 0, 0, 32'h40800000, 1'b0, 0);
    run_vec("stall", va, ones, 0, 0, 32'h41200000, 1'b0, 5);
    run_vec("after_stall", ones, ones, 0, 0, 32'h40800000, 1'b0, 0);
    run_vec("bubbles", va, ones, 1, 3, 32'h41200000, 1'b0, 0);

    // Reset in the middle of a vector discards the partial sum
    send_pair(32'h3F800000, 32'h3F800000);
    send_pair(32'h3F800000, 32'h3F800000);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_result", bus.out_result, 32'd0);
    chk("midrst_ovf", 32'(bus.out_overflow), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    run_vec("post_rst", pack4(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000), ones,
            0, 0, 32'h41000000, 1'b0, 0);

    // Random vectors of multiples of 0.5; exact sum kept in quarters
    for (int v = 0; v < 12; v++) begin
      sum = 0;
      for (int i = 0; i < LEN; i++) begin
        ka = int'($urandom_range(32)) - 16;
        kb = int'($urandom_range(32)) - 16;
        va[i] = to_fp(ka, 1);
        vb[i] = to_fp(kb, 1);
        sum += ka * kb;
      end
      run_vec("rand", va, vb, 0, 2, to_fp(sum, 2), 1'b0, int'($urandom_range(3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
